// File: rtl/md_scheduler.sv
// Multi-cycle HI/LO multiply/divide sequencer with fixed per-op latencies.
// Optional macro MD_SCHEDULER_CANCEL_EN adds a cancel input that flushes an in-flight op.
module md_scheduler #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
`ifdef MD_SCHEDULER_CANCEL_EN
  input  logic        cancel,
`endif
  input  logic        start,
  input  logic [2:0]  ctrl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        done,
  output logic        div_zero
);

  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MULT  = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_DIV   = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MTHI  = 3'b110;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q, hi_q, lo_q;
  logic        busy_q, done_q, dz_q;

  logic        cancel_w;
`ifdef MD_SCHEDULER_CANCEL_EN
  assign cancel_w = cancel;
`else
  assign cancel_w = 1'b0;
`endif

  // Result datapath works only on the latched operands, so A/B may move after acceptance.
  logic        is_signed, is_mult, b_zero;
  logic [63:0] ext_a, ext_b, prod_d;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot_d, rem_d;

  always_comb begin
    is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
    is_mult   = (op_q == OP_MULTU) || (op_q == OP_MULT);
    b_zero    = (b_q == 32'd0);
    ext_a     = is_signed ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    ext_b     = is_signed ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    prod_d    = ext_a * ext_b;
    // Signed divide via magnitudes: keeps 0x80000000 / -1 well defined.
    a_mag     = (is_signed && a_q[31]) ? -a_q : a_q;
    b_mag     = (is_signed && b_q[31]) ? -b_q : b_q;
    b_safe    = b_zero ? 32'd1 : b_mag;
    q_mag     = a_mag / b_safe;
    r_mag     = a_mag % b_safe;
    quot_d    = (is_signed && (a_q[31] ^ b_q[31])) ? -q_mag : q_mag;
    rem_d     = (is_signed && a_q[31]) ? -r_mag : r_mag;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !cancel_w) begin
            case (ctrl)
              OP_MULTU, OP_MULT, OP_DIVU, OP_DIV: begin
                a_q     <= A;
                b_q     <= B;
                op_q    <= ctrl;
                cnt_q   <= (ctrl == OP_MULTU || ctrl == OP_MULT) ? MULT_LOAD : DIV_LOAD;
                busy_q  <= 1'b1;
                state_q <= RUN;
              end
              OP_MTLO: lo_q <= A;
              OP_MTHI: hi_q <= A;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (cancel_w) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            if (is_mult) begin
              hi_q <= prod_d[63:32];
              lo_q <= prod_d[31:0];
            end else if (b_zero) begin
              dz_q <= 1'b1;
            end else begin
              hi_q <= rem_d;
              lo_q <= quot_d;
            end
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign HI       = hi_q;
  assign LO       = lo_q;
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_md_scheduler.sv
// Directed bench for md_scheduler: expected HI/LO/div_zero queued at issue, checked at done.
module tb_md_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  ctrl = 3'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        busy, done, div_zero;
  logic [31:0] HI, LO;
`ifdef MD_SCHEDULER_CANCEL_EN
  logic        cancel = 1'b0;
`endif

  md_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk),
    .reset(reset),
`ifdef MD_SCHEDULER_CANCEL_EN
    .cancel(cancel),
`endif
    .start(start),
    .ctrl(ctrl),
    .A(A),
    .B(B),
    .busy(busy),
    .HI(HI),
    .LO(LO),
    .done(done),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drives start for one edge from the current negedge; returns at the next negedge.
  task automatic issue(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; ctrl = c; A = a; B = b;
    @(negedge clk);
    start = 1'b0; ctrl = 3'd0; A = 32'hDEAD_BEEF; B = 32'hCAFE_F00D;
    $display("issue ctrl=%0d a=%h b=%h busy=%b", c, a, b, busy);
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("done_idle", 32'(done), 32'd0);
  endtask

  // Counts remaining busy cycles, then compares the commit against the scoreboard head.
  task automatic wait_done(input string tag, input int n_exp);
    int   cnt;
    exp_t e;
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, 32'(cnt), 32'(n_exp));
    chk({tag, "_done"}, 32'(done), 32'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      $display("done %s HI=%h LO=%h dz=%b", tag, HI, LO, div_zero);
      chk({tag, "_HI"}, HI, e.hi);
      chk({tag, "_LO"}, LO, e.lo);
      chk({tag, "_div_zero"}, 32'(div_zero), 32'(e.dz));
    end
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_HI", HI, 32'd0);
    chk("rst_LO", LO, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dz", 32'(div_zero), 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // mult -2 * 3
    sb.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFA, dz: 1'b0});
    issue(3'b010, 32'hFFFF_FFFE, 32'd3);
    wait_done("mult", 5);
    @(negedge clk);
    chk("done_one_pulse", 32'(done), 32'd0);

    // div -7 / 2, then divu of the same bits
    sb.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD, dz: 1'b0});
    issue(3'b100, 32'hFFFF_FFF9, 32'd2);
    wait_done("div", 10);
    sb.push_back('{hi: 32'd1, lo: 32'h7FFF_FFFC, dz: 1'b0});
    issue(3'b011, 32'hFFFF_FFF9, 32'd2);
    wait_done("divu", 10);
    @(negedge clk);

    // mtlo then mthi on consecutive edges
    start = 1'b1; ctrl = 3'b101; A = 32'h1234;
    @(negedge clk);
    $display("mtlo LO=%h busy=%b", LO, busy);
    chk("mtlo_LO", LO, 32'h1234);
    chk("mtlo_busy", 32'(busy), 32'd0);
    ctrl = 3'b110; A = 32'h5678;
    @(negedge clk);
    start = 1'b0; ctrl = 3'd0;
    $display("mthi HI=%h LO=%h busy=%b", HI, LO, busy);
    chk("mthi_HI", HI, 32'h5678);
    chk("mthi_LO", LO, 32'h1234);
    chk("mthi_busy", 32'(busy), 32'd0);

    // divide by zero keeps preloaded HI/LO
    start = 1'b1; ctrl = 3'b110; A = 32'hAA;
    @(negedge clk);
    ctrl = 3'b101; A = 32'hBB;
    @(negedge clk);
    start = 1'b0;
    sb.push_back('{hi: 32'hAA, lo: 32'hBB, dz: 1'b1});
    issue(3'b011, 32'd77, 32'd0);
    wait_done("divu_by_zero", 10);
    @(negedge clk);
    chk("dz_one_pulse", 32'(div_zero), 32'd0);

    // multu with dropped starts during RUN, then back-to-back divu and overflow div
    sb.push_back('{hi: 32'hFFFF_FFFE, lo: 32'h0000_0001, dz: 1'b0});
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    start = 1'b1; ctrl = 3'b011; A = 32'd50; B = 32'd3;
    @(negedge clk);
    ctrl = 3'b101; A = 32'd9;
    @(negedge clk);
    start = 1'b0; ctrl = 3'd0;
    wait_done("multu_ignore", 3);
    sb.push_back('{hi: 32'd2, lo: 32'd14, dz: 1'b0});
    issue(3'b011, 32'd100, 32'd7);
    wait_done("divu_b2b", 10);
    sb.push_back('{hi: 32'd0, lo: 32'h8000_0000, dz: 1'b0});
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", 10);
    @(negedge clk);

`ifdef MD_SCHEDULER_CANCEL_EN
    // cancel at cycle 3 of a div; HI=0, LO=0x80000000 must survive
    issue(3'b100, 32'd1000, 32'd3);
    @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    $display("cancel busy=%b HI=%h LO=%h", busy, HI, LO);
    chk("cancel_busy", 32'(busy), 32'd0);
    chk("cancel_HI", HI, 32'd0);
    chk("cancel_LO", LO, 32'h8000_0000);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("cancel_no_done", 32'(done), 32'd0);
    end
    cancel = 1'b1; start = 1'b1; ctrl = 3'b101; A = 32'h77;
    @(negedge clk);
    cancel = 1'b0; start = 1'b0; ctrl = 3'd0;
    chk("cancel_idle_mtlo", LO, 32'h8000_0000);
`endif

    // async reset at cycle 3 of a div, between clock edges
    issue(3'b100, 32'd1000, 32'd3);
    @(negedge clk); @(negedge clk);
    #2 reset = 1'b1;
    #1;
    $display("midreset busy=%b HI=%h LO=%h done=%b", busy, HI, LO, done);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_HI", HI, 32'd0);
    chk("midrst_LO", LO, 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("midrst_no_done", 32'(done), 32'd0);
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
